seq_gen: RTL and testbench
==========================

SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), one per line:
- PAT, 16'h1094, pattern digits emitted MSB nibble first: 1,0,9,4.
- FILL, 4'h7, filler digit emitted during gaps.
REQ-002 The block SHALL have these ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all state changes on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, request pulse; sampled only in IDLE.
- count, in, 4, number of pattern repetitions; latched on accepted start.
- gap, in, 3, filler digits between repetitions; latched on accepted start.
- dout, out, 4, current digit.
- dout_valid, out, 1, dout is valid.
- dout_ready, in, 1, sink accepts dout this cycle.
- busy, out, 1, high in any state other than IDLE.
- done, out, 1, one-cycle pulse at the end of a request.

Function
REQ-003 The FSM SHALL have four states: IDLE, EMIT, GAP and DONE, held in registers.
REQ-004 A handshake SHALL be defined as dout_valid && dout_ready at a rising edge; the digit index, gap counter and repetition counter SHALL advance only on a handshake.
REQ-005 While dout_valid is high and dout_ready is low, dout SHALL hold its value and dout_valid SHALL stay high.
REQ-006 From IDLE, start=1 with count!=0 SHALL:
- latch count into rep_cnt and gap into gap_reg;
- clear the digit index idx;
- go to EMIT, with dout_valid first high in the cycle after the start edge.
REQ-007 From IDLE, start=1 with count==0 SHALL go to DONE with no dout_valid at any point.
REQ-008 In EMIT, dout SHALL be nibble (3-idx) of PAT and dout_valid SHALL be 1.
REQ-009 A handshake in EMIT with idx<3 SHALL increment idx.
REQ-010 A handshake in EMIT with idx==3 SHALL decrement rep_cnt and then:
- go to DONE if rep_cnt==1;
- otherwise go to EMIT with idx=0 if gap_reg==0;
- otherwise go to GAP with gap_cnt=gap_reg.
REQ-011 In GAP, dout SHALL be FILL and dout_valid SHALL be 1.
REQ-012 A handshake in GAP SHALL decrement gap_cnt, and when gap_cnt==1 SHALL go to EMIT with idx=0.
REQ-013 DONE SHALL last exactly one cycle, with done=1 and dout_valid=0, and then go to IDLE.
REQ-014 Outside EMIT and GAP, dout_valid SHALL be 0 and dout SHALL be 4'h0.
REQ-015 start SHALL be ignored in EMIT, GAP and DONE; count and gap SHALL be sampled only on an accepted start.
REQ-016 With dout_ready held at 1, one request SHALL occupy 1 + 4*count + gap*(count-1) + 1 cycles, from the start edge through the done cycle.
REQ-017 All counters SHALL be unsigned at their declared widths, with no wrap: rep_cnt is 4 bits, idx is 2 bits, gap_cnt is 3 bits.

Reset
REQ-018 When rst_n=0, the block SHALL asynchronously force:
- state to IDLE;
- idx, rep_cnt, gap_cnt and gap_reg to 0;
- dout=0, dout_valid=0, busy=0, done=0.
REQ-019 A reset during EMIT or GAP SHALL abandon the request with no done pulse.
REQ-020 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-021 A shared package SHALL hold:
- the state enumeration (IDLE=2'b00, EMIT=2'b01, GAP=2'b10, DONE=2'b11);
- default PAT (16'h1094);
- default FILL (4'h7).
REQ-022 The block SHALL be a single module with no sub-module; the state register, counters and output decode SHALL live in seq_gen.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- count=1, gap=0, dout_ready=1 -> dout 1,0,9,4 on four consecutive cycles, then done=1 for one cycle, busy low after it.
- count=2, gap=2, dout_ready=1 -> dout 1,0,9,4,7,7,1,0,9,4, then done; 12 cycles total.
- count=1, dout_ready=0 for three cycles while dout=9 -> dout held at 9 with valid high; stream resumes with 4 and is otherwise unchanged.
- count=0 -> done pulses one cycle after the start edge; dout_valid never high.
- start pulsed with count=5 while busy in count=1 mode -> ignored; only one pattern emitted.
- rst_n pulled low mid-EMIT (after the 0 digit) -> outputs 0 immediately, no done; a following start with count=1 emits a full 1,0,9,4.
- Loopback into the existing 1-0-9-4 sequence detector with count=3, gap=1 -> exactly three detector y pulses.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// Shared types and defaults for the 1-0-9-4 digit sequence generator.
// Holds the FSM state encoding, default pattern/filler and the digit selector.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EMIT = 2'b01,
        GAP  = 2'b10,
        DONE = 2'b11
    } state_e;

    localparam logic [15:0] DEF_PAT  = 16'h1094;
    localparam logic [3:0]  DEF_FILL = 4'h7;

    // Digit 0 is the most significant nibble of the pattern.
    function automatic logic [3:0] pat_digit(input logic [15:0] pat, input logic [1:0] idx);
        logic [3:0] d;
        case (idx)
            2'd0:    d = pat[15:12];
            2'd1:    d = pat[11:8];
            2'd2:    d = pat[7:4];
            default: d = pat[3:0];
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seq_gen.sv
// Streams a 4-digit pattern count times, separated by gap filler digits,
// over a valid/ready interface; pulses done for one cycle at the end.
module seq_gen
    import seq_gen_pkg::*;
#(
    parameter logic [15:0] PAT  = DEF_PAT,
    parameter logic [3:0]  FILL = DEF_FILL
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] count,
    input  logic [2:0] gap,
    output logic [3:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       busy,
    output logic       done
);

    state_e     state, state_nxt;
    logic [1:0] idx, idx_nxt;
    logic [3:0] rep_cnt, rep_cnt_nxt;
    logic [2:0] gap_cnt, gap_cnt_nxt;
    logic [2:0] gap_reg, gap_reg_nxt;

    logic [3:0] dout_nxt;
    logic       dout_valid_nxt;
    logic       busy_nxt;
    logic       done_nxt;
    logic       hs;

    assign hs = dout_valid && dout_ready;

    // NOTE: every signal gets a default at the top of the block so no path
    // leaves it unassigned; that is what keeps always_comb free of latches.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        rep_cnt_nxt = rep_cnt;
        gap_cnt_nxt = gap_cnt;
        gap_reg_nxt = gap_reg;

        case (state)
            IDLE: begin
                if (start) begin
                    if (count != 4'd0) begin
                        rep_cnt_nxt = count;
                        gap_reg_nxt = gap;
                        idx_nxt     = 2'd0;
                        state_nxt   = EMIT;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            EMIT: begin
                if (hs) begin
                    if (idx != 2'd3) begin
                        idx_nxt = idx + 2'd1;
                    end else begin
                        rep_cnt_nxt = rep_cnt - 4'd1;
                        if (rep_cnt == 4'd1) begin
                            state_nxt = DONE;
                        end else if (gap_reg == 3'd0) begin
                            idx_nxt   = 2'd0;
                            state_nxt = EMIT;
                        end else begin
                            gap_cnt_nxt = gap_reg;
                            state_nxt   = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (hs) begin
                    gap_cnt_nxt = gap_cnt - 3'd1;
                    if (gap_cnt == 3'd1) begin
                        idx_nxt   = 2'd0;
                        state_nxt = EMIT;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they can be registered and
    // still line up with the state they describe.
    always_comb begin
        dout_nxt       = 4'h0;
        dout_valid_nxt = 1'b0;
        case (state_nxt)
            EMIT: begin
                dout_nxt       = pat_digit(PAT, idx_nxt);
                dout_valid_nxt = 1'b1;
            end
            GAP: begin
                dout_nxt       = FILL;
                dout_valid_nxt = 1'b1;
            end
            default: ;
        endcase
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    // NOTE: all state here is plain flops, so every register is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 2'd0;
            rep_cnt    <= 4'd0;
            gap_cnt    <= 3'd0;
            gap_reg    <= 3'd0;
            dout       <= 4'h0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            rep_cnt    <= rep_cnt_nxt;
            gap_cnt    <= gap_cnt_nxt;
            gap_reg    <= gap_reg_nxt;
            dout       <= dout_nxt;
            dout_valid <= dout_valid_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen: expected digits are queued when a request is
// driven and popped on every handshake; a behavioural 1-0-9-4 detector listens in.
module tb_seq_gen;

    localparam logic [15:0] TB_PAT  = 16'h1094;
    localparam logic [3:0]  TB_FILL = 4'h7;

    typedef enum int {M_PLAIN, M_HOLD, M_RESTART} mode_e;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] count = 4'd0;
    logic [2:0] gap = 3'd0;
    logic       dout_ready = 1'b1;
    logic [3:0] dout;
    logic       dout_valid;
    logic       busy;
    logic       done;

    int         n_tests = 0;
    int         n_fail = 0;
    logic [3:0] exp_q[$];
    logic [15:0] det_hist = 16'h0;
    int         det_hits = 0;

    seq_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .count      (count),
        .gap        (gap),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_expected(input int cnt, input int gp);
        logic [15:0] p;
        p = TB_PAT;
        for (int r = 0; r < cnt; r++) begin
            for (int i = 0; i < 4; i++) exp_q.push_back(p[15-4*i -: 4]);
            if (r < cnt - 1)
                for (int g = 0; g < gp; g++) exp_q.push_back(TB_FILL);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, so the falling edge
    // sees exactly what the next rising edge will sample.
    always @(negedge clk) begin
        if (rst_n && dout_valid && dout_ready) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("dout", 32'(dout), 32'(exp_q.pop_front()));
            det_hist = {det_hist[11:0], dout};
            if (det_hist == 16'h1094) det_hits++;
        end
    end

    task automatic run_req(input int cnt, input int gp, input mode_e mode);
        int k;
        int exp_cycles;
        bit held;
        k = 0;
        held = 1'b0;
        exp_cycles = (cnt == 0) ? 2 : 1 + 4*cnt + gp*(cnt-1) + 1;
        if (mode == M_HOLD) exp_cycles += 3;
        push_expected(cnt, gp);
        start = 1'b1;
        count = 4'(cnt);
        gap   = 3'(gp);
        @(posedge clk); #1;
        start = 1'b0;
        while (!done && k < 200) begin
            if (mode == M_RESTART && k == 2) begin
                start = 1'b1;
                count = 4'd5;
            end else if (mode == M_RESTART && k == 3) begin
                start = 1'b0;
                count = 4'(cnt);
            end
            if (mode == M_HOLD && !held && dout_valid && dout == 4'h9) begin
                dout_ready = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1;
                    k++;
                    check("hold_dout", 32'(dout), 32'h9);
                    check("hold_valid", 32'(dout_valid), 32'd1);
                end
                dout_ready = 1'b1;
                held = 1'b1;
            end
            @(posedge clk); #1;
            k++;
        end
        check("done_seen", 32'(done), 32'd1);
        check("cycles", 32'(k + 2), 32'(exp_cycles));
        check("done_valid_low", 32'(dout_valid), 32'd0);
        @(posedge clk); #1;
        check("done_width", 32'(done), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic reset_mid_emit();
        int k;
        k = 0;
        push_expected(1, 0);
        start = 1'b1;
        count = 4'd1;
        gap   = 3'd0;
        @(posedge clk); #1;
        start = 1'b0;
        while (!(dout_valid && dout == 4'h9) && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("saw_nine", 32'(dout), 32'h9);
        rst_n = 1'b0;
        #1;
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        exp_q.delete();
        #2 rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("no_done_after_rst", 32'(done), 32'd0);
            check("idle_after_rst", 32'(busy), 32'd0);
        end
        run_req(1, 0, M_PLAIN);
    endtask

    initial begin
        #2;
        check("reset_dout", 32'(dout), 32'h0);
        check("reset_valid", 32'(dout_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_req(1, 0, M_PLAIN);
        run_req(2, 2, M_PLAIN);
        run_req(1, 0, M_HOLD);
        run_req(0, 3, M_PLAIN);
        run_req(1, 0, M_RESTART);
        reset_mid_emit();

        @(negedge clk);
        det_hits = 0;
        det_hist = 16'h0;
        @(posedge clk); #1;
        run_req(3, 1, M_PLAIN);
        check("det_hits", 32'(det_hits), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
